// File: rtl/change_hopper_ctrl.sv
// change_hopper_ctrl: queues change-request pulses as pending coins and drives
// the nickel/dime hoppers one coin at a time through an eject/sense handshake
// with a jam timeout. Tracks inventory, low-change and latched fault status.
// Optional build macro HOPPER_AUDIT_EN adds the audit_cents running total.
module change_hopper_ctrl #(
   parameter int CNT_W    = 8,
   parameter int PEND_W   = 4,
   parameter int TIMEOUT  = 16,
   parameter int LOW_MARK = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             nickel_out,
   input  logic             dime_out,
   input  logic             two_dime_out,
   input  logic             load,
   input  logic [CNT_W-1:0] nickels,
   input  logic [CNT_W-1:0] dimes,
   input  logic             coin_sensed,
   input  logic             fault_clr,
   output logic             n_eject,
   output logic             d_eject,
   output logic             busy,
   output logic             low_change,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] nickel_cnt,
`ifdef HOPPER_AUDIT_EN
   output logic [CNT_W-1:0] dime_cnt,
   output logic [15:0]      audit_cents
`else
   output logic [CNT_W-1:0] dime_cnt
`endif
);

   localparam int                TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [PEND_W+1:0] PEND_MAX = (PEND_W+2)'((1 << PEND_W) - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  LOW_LVL  = CNT_W'(LOW_MARK);

   typedef enum logic [2:0] {S_IDLE, S_EJECT, S_WAIT, S_GAP, S_FAULT} state_t;

   state_t            state, state_nx;
   logic              sel_d, sel_d_nx;   // 1: serving a dime, 0: a nickel
   logic [TMO_W-1:0]  tmo, tmo_nx;
   logic [PEND_W-1:0] pend_n, pend_d, pend_n_nx, pend_d_nx;
   logic [PEND_W+1:0] sum_n, sum_d;
   logic [1:0]        code_nx;
   logic              retire, jam, dry, ovf, ret_n, ret_d;

   assign ret_n   = retire & ~sel_d;
   assign ret_d   = retire &  sel_d;
   assign n_eject = (state == S_EJECT) & ~sel_d;
   assign d_eject = (state == S_EJECT) &  sel_d;
   assign fault   = |fault_code;

   // Coin-serving FSM: pick dimes first, dry check, eject, wait for sensor, settle.
   always_comb begin
      state_nx = state;
      sel_d_nx = sel_d;
      tmo_nx   = tmo;
      retire   = 1'b0;
      jam      = 1'b0;
      dry      = 1'b0;
      case (state)
         S_IDLE: begin
            if (pend_d != '0) begin
               sel_d_nx = 1'b1;
               if (dime_cnt == '0) begin
                  dry      = 1'b1;
                  state_nx = S_FAULT;
               end else begin
                  state_nx = S_EJECT;
               end
            end else if (pend_n != '0) begin
               sel_d_nx = 1'b0;
               if (nickel_cnt == '0) begin
                  dry      = 1'b1;
                  state_nx = S_FAULT;
               end else begin
                  state_nx = S_EJECT;
               end
            end
         end
         S_EJECT: begin
            tmo_nx   = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (coin_sensed) begin
               retire   = 1'b1;
               state_nx = S_GAP;
            end else if (tmo == TMO_LAST) begin
               jam      = 1'b1;
               state_nx = S_FAULT;
            end else begin
               tmo_nx = tmo + TMO_W'(1);
            end
         end
         S_GAP:   state_nx = S_IDLE;
         S_FAULT: if (fault_clr) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Pending counters: enqueue and retire combine, result saturates.
   always_comb begin
      sum_n = {2'b00, pend_n} + {{(PEND_W+1){1'b0}}, nickel_out}
            - {{(PEND_W+1){1'b0}}, ret_n};
      sum_d = {2'b00, pend_d} + {{(PEND_W+1){1'b0}}, dime_out}
            + {{PEND_W{1'b0}}, two_dime_out, 1'b0}
            - {{(PEND_W+1){1'b0}}, ret_d};
      ovf       = (sum_n > PEND_MAX) | (sum_d > PEND_MAX);
      pend_n_nx = (sum_n > PEND_MAX) ? '1 : sum_n[PEND_W-1:0];
      pend_d_nx = (sum_d > PEND_MAX) ? '1 : sum_d[PEND_W-1:0];
   end

   // Fault code: clear first, then only the first new fault of the window sticks.
   always_comb begin
      code_nx = fault_clr ? 2'b00 : fault_code;
      if (code_nx == 2'b00) begin
         if (jam)      code_nx = 2'b01;
         else if (dry) code_nx = 2'b11;
         else if (ovf) code_nx = 2'b10;
      end
   end

   // FSM state, coin selection and timeout counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         sel_d <= 1'b0;
         tmo   <= '0;
      end else begin
         state <= state_nx;
         sel_d <= sel_d_nx;
         tmo   <= tmo_nx;
      end
   end

   // Pending coins and latched fault code.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_n     <= '0;
         pend_d     <= '0;
         fault_code <= 2'b00;
      end else begin
         pend_n     <= pend_n_nx;
         pend_d     <= pend_d_nx;
         fault_code <= code_nx;
      end
   end

   // Inventory: load beats a same-cycle retirement; never decrements below zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nickel_cnt <= '0;
         dime_cnt   <= '0;
      end else if (load) begin
         nickel_cnt <= nickels;
         dime_cnt   <= dimes;
      end else begin
         if (ret_n && nickel_cnt != '0) nickel_cnt <= nickel_cnt - CNT_W'(1);
         if (ret_d && dime_cnt   != '0) dime_cnt   <= dime_cnt   - CNT_W'(1);
      end
   end

   // Status flags, registered one cycle behind the state that drives them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy       <= 1'b0;
         low_change <= 1'b0;
      end else begin
         busy       <= (pend_n != '0) | (pend_d != '0) | (state != S_IDLE);
         low_change <= (nickel_cnt <= LOW_LVL) | (dime_cnt <= LOW_LVL);
      end
   end

`ifdef HOPPER_AUDIT_EN
   // Running total of cents actually dispensed, wraps at 16 bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    audit_cents <= 16'd0;
      else if (retire) audit_cents <= audit_cents + (sel_d ? 16'd10 : 16'd5);
   end
`endif

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Bench for change_hopper_ctrl: directed scenarios, a transaction-level coin
// model checked every cycle, and literal expectations per scenario.
module tb_change_hopper_ctrl;
   localparam int CNT_W = 8, PEND_W = 4, TIMEOUT = 16, LOW_MARK = 2;
   localparam int PMAX  = (1 << PEND_W) - 1;

   logic clk = 1'b0, reset_n = 1'b0;
   logic nickel_out = 0, dime_out = 0, two_dime_out = 0, load = 0;
   logic [CNT_W-1:0] nickels = '0, dimes = '0;
   logic coin_sensed = 0, fault_clr = 0;
   logic n_eject, d_eject, busy, low_change, fault;
   logic [1:0] fault_code;
   logic [CNT_W-1:0] nickel_cnt, dime_cnt;
`ifdef HOPPER_AUDIT_EN
   logic [15:0] audit_cents;
`endif

   change_hopper_ctrl #(.CNT_W(CNT_W), .PEND_W(PEND_W), .TIMEOUT(TIMEOUT), .LOW_MARK(LOW_MARK)) dut (
      .clk(clk), .reset_n(reset_n), .nickel_out(nickel_out), .dime_out(dime_out),
      .two_dime_out(two_dime_out), .load(load), .nickels(nickels), .dimes(dimes),
      .coin_sensed(coin_sensed), .fault_clr(fault_clr), .n_eject(n_eject), .d_eject(d_eject),
      .busy(busy), .low_change(low_change), .fault(fault), .fault_code(fault_code),
`ifdef HOPPER_AUDIT_EN
      .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .audit_cents(audit_cents)
`else
      .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- coin model ----------------
   int m_pn, m_pd, m_ninv, m_dinv, m_code, m_age, m_settle, m_audit;
   bit m_halt, m_out, m_out_d, m_low;
   int p_pn, p_pd, p_ninv, p_dinv;
   bit p_halt;
   int ej_n_cnt = 0, ej_d_cnt = 0;
   int sn, sd;
   bit ret_n, ret_d, ovf, timed_out;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_pn = 0; m_pd = 0; m_ninv = 0; m_dinv = 0; m_code = 0; m_age = 0;
         m_settle = 0; m_audit = 0; m_halt = 0; m_out = 0; m_out_d = 0; m_low = 0;
         p_pn = 0; p_pd = 0; p_ninv = 0; p_dinv = 0; p_halt = 0;
      end else begin
         chk("nickel_cnt", nickel_cnt, m_ninv);
         chk("dime_cnt", dime_cnt, m_dinv);
         chk("low_change", low_change, m_low);
         chk("eject_excl", n_eject & d_eject, 0);
         if (m_settle > 0) m_settle--;
         else begin
            chk("fault_code", fault_code, m_code);
            chk("fault", fault, m_code != 0);
         end
`ifdef HOPPER_AUDIT_EN
         chk("audit_cents", audit_cents, m_audit);
`endif
         // an eject is legal only if last cycle's queue/inventory called for it
         if (d_eject) begin
            ej_d_cnt++;
            chk("d_eject_legal", p_pd > 0 && p_dinv > 0 && !p_halt && !m_out, 1);
            m_out = 1; m_out_d = 1; m_age = 0;
         end
         if (n_eject) begin
            ej_n_cnt++;
            chk("n_eject_legal", p_pd == 0 && p_pn > 0 && p_ninv > 0 && !p_halt && !m_out, 1);
            m_out = 1; m_out_d = 0; m_age = 0;
         end
         p_pn = m_pn; p_pd = m_pd; p_ninv = m_ninv; p_dinv = m_dinv; p_halt = m_halt;
         m_low = (m_ninv <= LOW_MARK) || (m_dinv <= LOW_MARK);

         ret_n = 0; ret_d = 0; timed_out = 0;
         if (m_out) begin
            if (m_age >= 1 && coin_sensed) begin
               if (m_out_d) ret_d = 1; else ret_n = 1;
               m_out = 0;
            end else if (m_age == TIMEOUT) begin
               timed_out = 1;
               m_out = 0;
            end else m_age++;
         end
         if (fault_clr) begin m_code = 0; m_halt = 0; end
         sn = m_pn - int'(ret_n) + int'(nickel_out);
         sd = m_pd - int'(ret_d) + int'(dime_out) + 2 * int'(two_dime_out);
         ovf = (sn > PMAX) || (sd > PMAX);
         m_pn = (sn > PMAX) ? PMAX : sn;
         m_pd = (sd > PMAX) ? PMAX : sd;
         if (load) begin m_ninv = nickels; m_dinv = dimes; end
         else begin
            if (ret_n && m_ninv > 0) m_ninv--;
            if (ret_d && m_dinv > 0) m_dinv--;
         end
         if (ret_d) m_audit = (m_audit + 10) % 65536;
         if (ret_n) m_audit = (m_audit + 5) % 65536;
         if (timed_out) begin m_halt = 1; if (m_code == 0) m_code = 1; end
         if (ovf && m_code == 0) m_code = 2;
         // dry hopper: the next coin to serve has no inventory behind it
         if (!m_halt && !m_out &&
             ((m_pd > 0 && m_dinv == 0) || (m_pd == 0 && m_pn > 0 && m_ninv == 0))) begin
            m_halt = 1;
            if (m_code == 0) m_code = 3;
            m_settle = 4;
         end
      end
   end

   // ---------------- sensor responder ----------------
   bit resp_en = 0;
   int resp_lat = 1, cs_dly = 0;
   initial forever begin
      @(posedge clk); #1;
      coin_sensed = 0;
      if (cs_dly > 0) begin
         cs_dly--;
         if (cs_dly == 0) coin_sensed = 1;
      end
      if ((n_eject || d_eject) && resp_en) cs_dly = resp_lat;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_load(input int n, input int d);
      nickels = CNT_W'(n); dimes = CNT_W'(d); load = 1; tick(); load = 0;
   endtask

   task automatic wait_quiet(input string name);
      int q = 0, n = 0;
      while (q < 3 && n < 600) begin
         tick(); n++;
         q = (!busy && !n_eject && !d_eject) ? q + 1 : 0;
      end
      chk({name, "_quiet_in_time"}, n < 600, 1);
   endtask

   task automatic wait_eject(input string name);
      int n = 0;
      while (!(n_eject || d_eject) && n < 50) begin tick(); n++; end
      chk({name, "_eject_in_time"}, n < 50, 1);
   endtask

   int d0, n0;

   initial begin
      // reset state
      tick(3);
      chk("rst_n_eject", n_eject, 0);   chk("rst_d_eject", d_eject, 0);
      chk("rst_busy", busy, 0);         chk("rst_low", low_change, 0);
      chk("rst_fault", fault, 0);       chk("rst_code", fault_code, 0);
      chk("rst_ncnt", nickel_cnt, 0);   chk("rst_dcnt", dime_cnt, 0);
      reset_n = 1;
      tick(2);

      // S1: single dime, sensor 2 cycles after eject
      do_load(2, 15); resp_en = 1; resp_lat = 2; d0 = ej_d_cnt;
      dime_out = 1; tick(); dime_out = 0;
      tick();
      chk("s1_busy_up", busy, 1);
      wait_quiet("s1");
      chk("s1_d_ejects", ej_d_cnt - d0, 1);
      chk("s1_dime_cnt", dime_cnt, 14);
      chk("s1_busy", busy, 0);
      chk("s1_fault", fault, 0);

      // S2: all three requests in one cycle, immediate sensor
      do_load(2, 15); resp_lat = 1; d0 = ej_d_cnt; n0 = ej_n_cnt;
      nickel_out = 1; dime_out = 1; two_dime_out = 1; tick();
      nickel_out = 0; dime_out = 0; two_dime_out = 0;
      wait_quiet("s2");
      chk("s2_d_ejects", ej_d_cnt - d0, 3);
      chk("s2_n_ejects", ej_n_cnt - n0, 1);
      chk("s2_dime_cnt", dime_cnt, 12);
      chk("s2_nickel_cnt", nickel_cnt, 1);
      chk("s2_low", low_change, 1);

      // S3: jam timeout, then clear re-ejects the same dime
      resp_en = 0; d0 = ej_d_cnt;
      dime_out = 1; tick(); dime_out = 0;
      wait_eject("s3");
      tick(TIMEOUT);
      chk("s3_no_fault_yet", fault, 0);
      tick();
      chk("s3_fault", fault, 1);
      chk("s3_code", fault_code, 1);
      resp_en = 1;
      fault_clr = 1; tick(); fault_clr = 0;
      wait_quiet("s3");
      chk("s3_d_ejects", ej_d_cnt - d0, 2);
      chk("s3_dime_cnt", dime_cnt, 11);
      chk("s3_code_clr", fault_code, 0);

      // S4: dry nickel hopper, reload and clear
      do_load(0, 11); n0 = ej_n_cnt;
      nickel_out = 1; tick(); nickel_out = 0;
      tick(10);
      chk("s4_no_eject", ej_n_cnt - n0, 0);
      chk("s4_code", fault_code, 3);
      chk("s4_busy", busy, 1);
      do_load(5, 11);
      fault_clr = 1; tick(); fault_clr = 0;
      wait_quiet("s4");
      chk("s4_n_ejects", ej_n_cnt - n0, 1);
      chk("s4_nickel_cnt", nickel_cnt, 4);
      chk("s4_code_clr", fault_code, 0);

      // S5: saturate pend_d while jammed; first code retained
      do_load(5, 40); resp_en = 0; d0 = ej_d_cnt;
      dime_out = 1; tick(); dime_out = 0;
      tick(TIMEOUT + 6);
      chk("s5_code_jam", fault_code, 1);
      two_dime_out = 1; tick(8); two_dime_out = 0;
      tick(2);
      chk("s5_code_kept", fault_code, 1);
      resp_en = 1; resp_lat = 1;
      fault_clr = 1; tick(); fault_clr = 0;
      wait_quiet("s5");
      chk("s5_d_ejects", ej_d_cnt - d0, 16);
      chk("s5_dime_cnt", dime_cnt, 25);

      // S6: overflow while serving; FSM keeps dispensing
      do_load(5, 40); d0 = ej_d_cnt;
      two_dime_out = 1; tick(10); two_dime_out = 0;
      tick();
      chk("s6_code_ovf", fault_code, 2);
      chk("s6_fault", fault, 1);
      wait_quiet("s6");
      chk("s6_d_ejects", ej_d_cnt - d0, 17);
      chk("s6_dime_cnt", dime_cnt, 23);
      fault_clr = 1; tick(); fault_clr = 0;
      chk("s6_code_clr", fault_code, 0);

      // S7: reset in the middle of a nickel eject
      do_load(5, 40); resp_en = 0;
      nickel_out = 1; tick(); nickel_out = 0;
      wait_eject("s7");
      chk("s7_n_eject_on", n_eject, 1);
      #2 reset_n = 0;
      #1;
      chk("s7_n_eject_off", n_eject, 0);
      chk("s7_ncnt", nickel_cnt, 0);
      chk("s7_dcnt", dime_cnt, 0);
      chk("s7_busy", busy, 0);
      tick(2);
      reset_n = 1;
      tick(2);
      chk("s7_no_eject", n_eject | d_eject, 0);

`ifdef HOPPER_AUDIT_EN
      // audit: two dimes plus one nickel
      do_load(5, 40); resp_en = 1; resp_lat = 1;
      dime_out = 1; tick(); dime_out = 0;
      dime_out = 1; tick(); dime_out = 0;
      nickel_out = 1; tick(); nickel_out = 0;
      wait_quiet("audit");
      chk("audit_25", audit_cents, 25);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1);
   end
endmodule
